// File: rtl/ecdh_mul_if.sv
// Start/done handshake and operand bus between the ECDH sequencer and the
// single time-shared point multiplier.
interface ecdh_mul_if #(
    parameter int W  = 5,
    parameter int KW = 4
);
    logic          mul_start;
    logic [W-1:0]  mul_p;
    logic [W-1:0]  mul_px;
    logic [W-1:0]  mul_py;
    logic [KW-1:0] mul_k;
    logic          mul_done;
    logic [W-1:0]  mul_rx;
    logic [W-1:0]  mul_ry;

    modport master (
        output mul_start, mul_p, mul_px, mul_py, mul_k,
        input  mul_done, mul_rx, mul_ry
    );

    modport slave (
        input  mul_start, mul_p, mul_px, mul_py, mul_k,
        output mul_done, mul_rx, mul_ry
    );
endinterface

// File: rtl/ecdh_sequencer.sv
// Runs the four ECDH scalar-multiplication jobs on one shared multiplier,
// latches public keys and secrets, and cross-checks the two secrets.
//
// state | meaning
// IDLE  | waiting for start; results and match hold
// ISSUE | present job operands, pulse mul_start on exit
// WAIT  | operands held, waiting for mul_done or timeout
// CHECK | compare Alice-side and Bob-side secrets
// DONE  | pulse done, drop busy
// ERR   | set sticky error, drop busy
module ecdh_sequencer #(
    parameter int W       = 5,
    parameter int KW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [W-1:0]  p_i,
    input  logic [W-1:0]  gx_i,
    input  logic [W-1:0]  gy_i,
    input  logic [KW-1:0] alice_key_i,
    input  logic [KW-1:0] bob_key_i,
    ecdh_mul_if.master    mul,
    output logic [W-1:0]  alice_x_o,
    output logic [W-1:0]  alice_y_o,
    output logic [W-1:0]  bob_x_o,
    output logic [W-1:0]  bob_y_o,
    output logic [W-1:0]  secret_x_o,
    output logic [W-1:0]  secret_y_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          match_o,
    output logic          error_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE, ERR} state_t;

    state_t        state_q;
    logic [1:0]    job_q, job_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  p_q, gx_q, gy_q;
    logic [KW-1:0] ak_q, bk_q;
    logic [W-1:0]  alice_x_q, alice_y_q, bob_x_q, bob_y_q;
    logic [W-1:0]  secret_x_q, secret_y_q, chk_x_q, chk_y_q;
    logic          mul_start_q;
    logic [W-1:0]  mul_p_q, mul_px_q, mul_py_q;
    logic [KW-1:0] mul_k_q;
    logic          busy_q, done_q, match_q, error_q;

    assign job_d = job_q + 2'd1;
    assign cnt_d = cnt_q + TW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            job_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            ak_q        <= '0;
            bk_q        <= '0;
            alice_x_q   <= '0;
            alice_y_q   <= '0;
            bob_x_q     <= '0;
            bob_y_q     <= '0;
            secret_x_q  <= '0;
            secret_y_q  <= '0;
            chk_x_q     <= '0;
            chk_y_q     <= '0;
            mul_start_q <= 1'b0;
            mul_p_q     <= '0;
            mul_px_q    <= '0;
            mul_py_q    <= '0;
            mul_k_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        p_q     <= p_i;
                        gx_q    <= gx_i;
                        gy_q    <= gy_i;
                        ak_q    <= alice_key_i;
                        bk_q    <= bob_key_i;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                        match_q <= 1'b0;
                        job_q   <= '0;
                        // A zero key would make every product the point at infinity.
                        state_q <= (alice_key_i == '0 || bob_key_i == '0) ? ERR : ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start_q <= 1'b1;
                    cnt_q       <= '0;
                    mul_p_q     <= p_q;
                    case (job_q)
                        2'd0: begin
                            mul_px_q <= gx_q;
                            mul_py_q <= gy_q;
                            mul_k_q  <= ak_q;
                        end
                        2'd1: begin
                            mul_px_q <= gx_q;
                            mul_py_q <= gy_q;
                            mul_k_q  <= bk_q;
                        end
                        2'd2: begin
                            mul_px_q <= bob_x_q;
                            mul_py_q <= bob_y_q;
                            mul_k_q  <= ak_q;
                        end
                        default: begin
                            mul_px_q <= alice_x_q;
                            mul_py_q <= alice_y_q;
                            mul_k_q  <= bk_q;
                        end
                    endcase
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (mul.mul_done) begin
                        case (job_q)
                            2'd0: begin
                                alice_x_q <= mul.mul_rx;
                                alice_y_q <= mul.mul_ry;
                            end
                            2'd1: begin
                                bob_x_q <= mul.mul_rx;
                                bob_y_q <= mul.mul_ry;
                            end
                            2'd2: begin
                                secret_x_q <= mul.mul_rx;
                                secret_y_q <= mul.mul_ry;
                            end
                            default: begin
                                chk_x_q <= mul.mul_rx;
                                chk_y_q <= mul.mul_ry;
                            end
                        endcase
                        if (job_q == 2'd3) begin
                            state_q <= CHECK;
                        end else begin
                            job_q   <= job_d;
                            state_q <= ISSUE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TW'(TIMEOUT)) begin
                            state_q <= ERR;
                        end
                    end
                end
                CHECK: begin
                    match_q <= (secret_x_q == chk_x_q) && (secret_y_q == chk_y_q);
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                ERR: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul.mul_start = mul_start_q;
    assign mul.mul_p     = mul_p_q;
    assign mul.mul_px    = mul_px_q;
    assign mul.mul_py    = mul_py_q;
    assign mul.mul_k     = mul_k_q;

    assign alice_x_o  = alice_x_q;
    assign alice_y_o  = alice_y_q;
    assign bob_x_o    = bob_x_q;
    assign bob_y_o    = bob_y_q;
    assign secret_x_o = secret_x_q;
    assign secret_y_o = secret_y_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign match_o    = match_q;
    assign error_o    = error_q;
endmodule

// File: tb/tb_ecdh_sequencer.sv
// Self-checking bench for ecdh_sequencer: a scripted multiplier responder plus
// a job-table / latency reference model computed from the exchange rules.
module tb_ecdh_sequencer;
    localparam int W       = 5;
    localparam int KW      = 4;
    localparam int TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  p = '0, gx = '0, gy = '0;
    logic [KW-1:0] ak = '0, bk = '0;
    logic [W-1:0]  alice_x, alice_y, bob_x, bob_y, secret_x, secret_y;
    logic          busy, done, match, error;

    always #5 clk = ~clk;

    ecdh_mul_if #(.W(W), .KW(KW)) mul ();

    ecdh_sequencer #(.W(W), .KW(KW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .p_i(p), .gx_i(gx), .gy_i(gy), .alice_key_i(ak), .bob_key_i(bk),
        .mul(mul),
        .alice_x_o(alice_x), .alice_y_o(alice_y), .bob_x_o(bob_x), .bob_y_o(bob_y),
        .secret_x_o(secret_x), .secret_y_o(secret_y),
        .busy_o(busy), .done_o(done), .match_o(match), .error_o(error)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Multiplier responder configuration and observations, indexed by job.
    int           lat[4];
    logic [W-1:0] rsp_x[4], rsp_y[4];
    bit           silent[4];
    int           sbase = 0;
    int           n_starts = 0;
    int           unstable = 0;
    logic [W-1:0] op_p[4], op_x[4], op_y[4];
    logic [KW-1:0] op_k[4];
    int           st_cyc[4];
    logic         model_done = 1'b0, stray_done = 1'b0;
    logic [W-1:0] model_rx = '0, model_ry = '0;

    assign mul.mul_done = model_done | stray_done;
    assign mul.mul_rx   = stray_done ? {W{1'b1}} : model_rx;
    assign mul.mul_ry   = stray_done ? {W{1'b1}} : model_ry;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin : responder
        int j;
        forever begin
            @(negedge clk);
            if (mul.mul_start === 1'b1) begin
                j = n_starts - sbase;
                n_starts = n_starts + 1;
                if (j >= 0 && j < 4) begin
                    op_p[j] = mul.mul_p;
                    op_x[j] = mul.mul_px;
                    op_y[j] = mul.mul_py;
                    op_k[j] = mul.mul_k;
                    st_cyc[j] = cyc;
                    if (!silent[j]) begin
                        for (int c = 0; c < lat[j]; c++) begin
                            @(negedge clk);
                            if (mul.mul_p !== op_p[j] || mul.mul_px !== op_x[j] ||
                                mul.mul_py !== op_y[j] || mul.mul_k !== op_k[j])
                                unstable = unstable + 1;
                        end
                        model_rx = rsp_x[j];
                        model_ry = rsp_y[j];
                        model_done = 1'b1;
                        @(negedge clk);
                        model_done = 1'b0;
                    end
                end
            end
        end
    end

    // Reference: operands each job must present, from the exchange's job table.
    function automatic logic [3*W+KW-1:0] exp_op(input int j, input logic [W-1:0] tp, tgx, tgy,
                                                  input logic [KW-1:0] tak, tbk);
        case (j)
            0: return {tp, tgx, tgy, tak};
            1: return {tp, tgx, tgy, tbk};
            2: return {tp, rsp_x[1], rsp_y[1], tak};
            default: return {tp, rsp_x[0], rsp_y[0], tbk};
        endcase
    endfunction

    // Reference: each job costs its multiplier latency plus issue and capture, plus check and done.
    function automatic int exp_latency();
        int s;
        s = 2;
        for (int j = 0; j < 4; j++) s += lat[j] + 2;
        return s;
    endfunction

    task automatic do_start(input logic [W-1:0] tp, tgx, tgy, input logic [KW-1:0] tak, tbk);
        @(negedge clk);
        p = tp; gx = tgx; gy = tgy; ak = tak; bk = tbk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int l, output bit to);
        int k;
        k = 0; to = 1'b1; l = -1;
        while (k <= limit) begin
            if (done === 1'b1) begin
                l = k; to = 1'b0;
                break;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run_exchange(input logic [W-1:0] tp, tgx, tgy, input logic [KW-1:0] tak, tbk,
                                output int l, output bit to);
        sbase = n_starts;
        do_start(tp, tgx, tgy, tak, tbk);
        wait_done(3000, l, to);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, match} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags actual=%b required=0000", {busy, done, error, match});
        end
        checks++;
        if ({alice_x, alice_y, bob_x, bob_y, secret_x, secret_y} !== '0) begin
            failures++;
            $display("FAIL reset_results actual=%h required=0", {alice_x, alice_y, bob_x, bob_y, secret_x, secret_y});
        end
        checks++;
        if ({mul.mul_start, mul.mul_p, mul.mul_px, mul.mul_py, mul.mul_k} !== '0) begin
            failures++;
            $display("FAIL reset_mul_bus actual=%h required=0", {mul.mul_start, mul.mul_p, mul.mul_px, mul.mul_py, mul.mul_k});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int l, ub; bit to;
        lat = '{1, 1, 1, 1};
        rsp_x = '{5'd3, 5'd8, 5'd6, 5'd6};
        rsp_y = '{5'd4, 5'd2, 5'd9, 5'd9};
        silent = '{0, 0, 0, 0};
        ub = unstable;
        run_exchange(5'd17, 5'd1, 5'd5, 4'd5, 4'd7, l, to);
        checks++;
        if (to || l !== exp_latency()) begin
            failures++;
            $display("FAIL nominal_latency actual=%0d timeout=%0d required=%0d", l, to, exp_latency());
        end
        checks++;
        if (n_starts - sbase !== 4) begin
            failures++;
            $display("FAIL nominal_start_count actual=%0d required=4", n_starts - sbase);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({op_p[j], op_x[j], op_y[j], op_k[j]} !== exp_op(j, 5'd17, 5'd1, 5'd5, 4'd5, 4'd7)) begin
                failures++;
                $display("FAIL nominal_operands job%0d actual=%h required=%h", j,
                         {op_p[j], op_x[j], op_y[j], op_k[j]}, exp_op(j, 5'd17, 5'd1, 5'd5, 4'd5, 4'd7));
            end
        end
        checks++;
        if ({alice_x, alice_y, bob_x, bob_y, secret_x, secret_y} !== {5'd3, 5'd4, 5'd8, 5'd2, 5'd6, 5'd9}) begin
            failures++;
            $display("FAIL nominal_results actual=%0d,%0d %0d,%0d %0d,%0d required=3,4 8,2 6,9",
                     alice_x, alice_y, bob_x, bob_y, secret_x, secret_y);
        end
        checks++;
        if ({match, error, busy} !== 3'b100) begin
            failures++;
            $display("FAIL nominal_flags match/error/busy actual=%b required=100", {match, error, busy});
        end
        @(negedge clk);
        checks++;
        if ({done, busy, match} !== 3'b001) begin
            failures++;
            $display("FAIL nominal_after done/busy/match actual=%b required=001", {done, busy, match});
        end
        checks++;
        if (unstable - ub !== 0) begin
            failures++;
            $display("FAIL nominal_operand_stability actual=%0d changes required=0", unstable - ub);
        end
    endtask

    task automatic test_mismatch();
        int l; bit to;
        lat = '{1, 1, 1, 1};
        rsp_x = '{5'd3, 5'd8, 5'd6, 5'd6};
        rsp_y = '{5'd4, 5'd2, 5'd9, 5'd8};
        silent = '{0, 0, 0, 0};
        run_exchange(5'd17, 5'd1, 5'd5, 4'd5, 4'd7, l, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL mismatch_done actual=no_done required=done");
        end
        checks++;
        if ({secret_x, secret_y, match, error} !== {5'd6, 5'd9, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mismatch_result secret=%0d,%0d match=%b error=%b required=6,9 0 0",
                     secret_x, secret_y, match, error);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int ecyc, db; bit seen;
        lat = '{1, 1, 1, 1};
        rsp_x = '{5'd3, 5'd8, 5'd6, 5'd6};
        rsp_y = '{5'd4, 5'd2, 5'd9, 5'd9};
        silent = '{0, 1, 0, 0};
        sbase = n_starts;
        db = done_cnt;
        do_start(5'd17, 5'd1, 5'd5, 4'd5, 4'd7);
        seen = 1'b0; ecyc = 0;
        for (int c = 0; c < 600; c++) begin
            if (error === 1'b1) begin
                seen = 1'b1; ecyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen || ecyc - st_cyc[1] !== TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_error_time seen=%b actual=%0d required=%0d", seen, ecyc - st_cyc[1], TIMEOUT + 1);
        end
        checks++;
        if (n_starts - sbase !== 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_state starts=%0d busy=%b required=2 0", n_starts - sbase, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - db !== 0 || {alice_x, alice_y} !== {5'd3, 5'd4} || error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_retain done_pulses=%0d alice=%0d,%0d error=%b required=0 3,4 1",
                     done_cnt - db, alice_x, alice_y, error);
        end
        silent = '{0, 0, 0, 0};
    endtask

    task automatic test_zero_key();
        int l; bit to;
        sbase = n_starts;
        do_start(5'd17, 5'd1, 5'd5, 4'd5, 4'd0);
        @(negedge clk);
        checks++;
        if ({error, busy} !== 2'b10) begin
            failures++;
            $display("FAIL zero_key_error error/busy actual=%b required=10", {error, busy});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_starts - sbase !== 0) begin
            failures++;
            $display("FAIL zero_key_no_start actual=%0d pulses required=0", n_starts - sbase);
        end
        lat = '{2, 1, 3, 1};
        rsp_x = '{5'd3, 5'd8, 5'd6, 5'd6};
        rsp_y = '{5'd4, 5'd2, 5'd9, 5'd9};
        run_exchange(5'd17, 5'd1, 5'd5, 4'd5, 4'd7, l, to);
        checks++;
        if (to || error !== 1'b0 || match !== 1'b1 || l !== exp_latency()) begin
            failures++;
            $display("FAIL zero_key_recover timeout=%0d error=%b match=%b latency=%0d required=0 0 1 %0d",
                     to, error, match, l, exp_latency());
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int l; bit to;
        lat = '{1, 1, 1, 1};
        rsp_x = '{5'd3, 5'd8, 5'd6, 5'd6};
        rsp_y = '{5'd4, 5'd2, 5'd9, 5'd9};
        silent = '{0, 0, 1, 0};
        sbase = n_starts;
        do_start(5'd17, 5'd1, 5'd5, 4'd5, 4'd7);
        for (int c = 0; c < 100 && (n_starts - sbase) < 3; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, error, match, alice_x, alice_y, bob_x, bob_y, secret_x, secret_y} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs actual=%h required=0",
                     {busy, done, error, match, alice_x, alice_y, bob_x, bob_y, secret_x, secret_y});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_starts - sbase !== 3 || {mul.mul_start, mul.mul_p, mul.mul_px, mul.mul_py, mul.mul_k} !== '0) begin
            failures++;
            $display("FAIL mid_reset_idle starts=%0d bus=%h required=3 0", n_starts - sbase,
                     {mul.mul_start, mul.mul_p, mul.mul_px, mul.mul_py, mul.mul_k});
        end
        silent = '{0, 0, 0, 0};
        run_exchange(5'd17, 5'd1, 5'd5, 4'd5, 4'd7, l, to);
        checks++;
        if (to || {secret_x, secret_y, match} !== {5'd6, 5'd9, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset_rerun timeout=%0d secret=%0d,%0d match=%b required=0 6,9 1",
                     to, secret_x, secret_y, match);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int l, ub, db; bit to;
        lat = '{1, 7, 3, 20};
        rsp_x = '{5'd3, 5'd8, 5'd6, 5'd6};
        rsp_y = '{5'd4, 5'd2, 5'd9, 5'd9};
        silent = '{0, 0, 0, 0};
        ub = unstable;
        db = done_cnt;
        sbase = n_starts;
        fork
            run_exchange(5'd17, 5'd1, 5'd5, 4'd5, 4'd7, l, to);
            begin
                @(negedge clk);
                for (int c = 0; c < 300 && (n_starts - sbase) < 2; c++) @(negedge clk);
                @(negedge clk);
                p = 5'd29; gx = 5'd2; gy = 5'd2; ak = 4'd3; bk = 4'd9;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        checks++;
        if (to || l !== exp_latency()) begin
            failures++;
            $display("FAIL busy_start_latency actual=%0d timeout=%0d required=%0d", l, to, exp_latency());
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({op_p[j], op_x[j], op_y[j], op_k[j]} !== exp_op(j, 5'd17, 5'd1, 5'd5, 4'd5, 4'd7)) begin
                failures++;
                $display("FAIL busy_start_operands job%0d actual=%h required=%h", j,
                         {op_p[j], op_x[j], op_y[j], op_k[j]}, exp_op(j, 5'd17, 5'd1, 5'd5, 4'd5, 4'd7));
            end
        end
        checks++;
        if (unstable - ub !== 0) begin
            failures++;
            $display("FAIL busy_start_stability actual=%0d changes required=0", unstable - ub);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - db !== 1 || n_starts - sbase !== 4 || busy !== 1'b0 || match !== 1'b1) begin
            failures++;
            $display("FAIL busy_start_ignored done_pulses=%0d starts=%0d busy=%b match=%b required=1 4 0 1",
                     done_cnt - db, n_starts - sbase, busy, match);
        end
    endtask

    task automatic test_random();
        int l; bit to, exp_m;
        logic [W-1:0] tp, tgx, tgy;
        logic [KW-1:0] tak, tbk;
        for (int it = 0; it < 20; it++) begin
            tp = W'($urandom); tgx = W'($urandom); tgy = W'($urandom);
            tak = KW'($urandom_range(15, 1)); tbk = KW'($urandom_range(15, 1));
            for (int j = 0; j < 4; j++) begin
                lat[j] = $urandom_range(6, 1);
                rsp_x[j] = W'($urandom);
                rsp_y[j] = W'($urandom);
                silent[j] = 1'b0;
            end
            if ($urandom_range(1, 0) == 1) begin
                rsp_x[3] = rsp_x[2];
                rsp_y[3] = rsp_y[2];
            end
            exp_m = (rsp_x[2] == rsp_x[3]) && (rsp_y[2] == rsp_y[3]);
            run_exchange(tp, tgx, tgy, tak, tbk, l, to);
            checks++;
            if (to || l !== exp_latency()) begin
                failures++;
                $display("FAIL random_latency iter%0d actual=%0d timeout=%0d required=%0d", it, l, to, exp_latency());
            end
            checks++;
            if ({op_p[2], op_x[2], op_y[2], op_k[2], op_p[3], op_x[3], op_y[3], op_k[3]} !==
                {exp_op(2, tp, tgx, tgy, tak, tbk), exp_op(3, tp, tgx, tgy, tak, tbk)} ||
                {op_p[0], op_x[0], op_y[0], op_k[0], op_p[1], op_x[1], op_y[1], op_k[1]} !==
                {exp_op(0, tp, tgx, tgy, tak, tbk), exp_op(1, tp, tgx, tgy, tak, tbk)}) begin
                failures++;
                $display("FAIL random_operands iter%0d job2=%h job3=%h required %h %h", it,
                         {op_p[2], op_x[2], op_y[2], op_k[2]}, {op_p[3], op_x[3], op_y[3], op_k[3]},
                         exp_op(2, tp, tgx, tgy, tak, tbk), exp_op(3, tp, tgx, tgy, tak, tbk));
            end
            checks++;
            if ({alice_x, alice_y, bob_x, bob_y, secret_x, secret_y, match, error} !==
                {rsp_x[0], rsp_y[0], rsp_x[1], rsp_y[1], rsp_x[2], rsp_y[2], exp_m, 1'b0}) begin
                failures++;
                $display("FAIL random_results iter%0d actual=%h required=%h", it,
                         {alice_x, alice_y, bob_x, bob_y, secret_x, secret_y, match, error},
                         {rsp_x[0], rsp_y[0], rsp_x[1], rsp_y[1], rsp_x[2], rsp_y[2], exp_m, 1'b0});
            end
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        lat = '{1, 1, 1, 1};
        silent = '{0, 0, 0, 0};
        rsp_x = '{5'd0, 5'd0, 5'd0, 5'd0};
        rsp_y = '{5'd0, 5'd0, 5'd0, 5'd0};
        test_reset();
        test_nominal();
        test_mismatch();
        test_timeout();
        test_zero_key();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
